// File: rtl/ai_conv_engine.sv
// Sequential N x N tile / K x K kernel valid convolution, one MAC per clock, with mean/variance post-processing.
// Optional AI_CONV_BOX_FILTER_EN adds box_sel, which reloads the kernel with all ones while idle.
module ai_conv_engine #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int K      = 3,
    parameter int ACC_W  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        accel_select,
    input  logic [31:0] data_in,
`ifdef AI_CONV_BOX_FILTER_EN
    input  logic        box_sel,
`endif
    output logic [31:0] data_out,
    output logic [15:0] ctr,
    output logic        busy,
    output logic        irq
);
    localparam int M      = N - K + 1;
    localparam int MM     = M * M;
    localparam int NN     = N * N;
    localparam int KK     = K * K;
    localparam int LOG_MM = $clog2(MM);
    localparam int SUM_W  = DATA_W + LOG_MM;
    localparam int VAR_W  = 2 * DATA_W + LOG_MM;
    localparam int CW     = $clog2(N + 1);
    localparam int NIW    = (NN > 1) ? $clog2(NN) : 1;
    localparam int KIW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int RIW    = (MM > 1) ? $clog2(MM) : 1;
    localparam logic [DATA_W-1:0] MAXV   = '1;
    localparam logic [CW-1:0]     K_LAST = CW'(K - 1);
    localparam logic [CW-1:0]     M_LAST = CW'(M - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_MEAN = 3'd2;
    localparam logic [2:0] S_VAR  = 3'd3;
    localparam logic [2:0] S_VFIN = 3'd4;

    if (((MM & (MM - 1)) != 0) || (K > N)) begin : g_bad_params
        $error("ai_conv_engine: M*M must be a power of two and K<=N");
    end

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] tile_q [NN];
    logic [DATA_W-1:0] kern_q [KK];
    logic [DATA_W-1:0] res_q  [MM];
    logic [DATA_W-1:0] mean_q, var_q;
    logic [ACC_W-1:0]  acc_q;
    logic [VAR_W-1:0]  vacc_q;
    logic [CW-1:0]     or_q, oc_q, kr_q, kc_q;
    logic [RIW-1:0]    vidx_q;
    logic [15:0]       ctr_q;
    logic              done_q, irq_q;
    logic [1:0]        mode_q;

    // Bus decode; only the word index and the element bits are meaningful.
    logic [9:0] widx;
    logic [5:0] woff;
    logic       we, idle, go, is_tile, is_kern, is_res, tile_wr, kern_wr, mode_wr;
    logic       unused_bits;
    assign widx        = addr[11:2];
    assign woff        = widx[5:0];
    assign unused_bits = ^{addr[31:12], addr[1:0], data_in[31:DATA_W]};
    assign we      = wr_en & accel_select;
    assign idle    = (state_q == S_IDLE);
    assign is_tile = (widx[9:6] == 4'd1) && ({1'b0, woff} < 7'(NN));
    assign is_kern = (widx[9:6] == 4'd2) && ({1'b0, woff} < 7'(KK));
    assign is_res  = (widx[9:6] == 4'd3) && ({1'b0, woff} < 7'(MM));
    assign go      = we && (widx == 10'd0) && idle;
    assign tile_wr = we && is_tile && idle;
    assign kern_wr = we && is_kern && idle;
    assign mode_wr = we && (widx == 10'd2) && idle;

    // MAC datapath: output (or,oc), tap (kr,kc), tap index innermost.
    logic [NIW-1:0]      tidx;
    logic [KIW-1:0]      kidx;
    logic [RIW-1:0]      ridx;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   prod_c, acc_sat;
    logic [ACC_W-1:0]    acc_sum;
    logic                tap_last, mac_last;
    assign tidx     = NIW'((int'(or_q) + int'(kr_q)) * N + int'(oc_q) + int'(kc_q));
    assign kidx     = KIW'(int'(kr_q) * K + int'(kc_q));
    assign ridx     = RIW'(int'(or_q) * M + int'(oc_q));
    assign prod     = (2*DATA_W)'(tile_q[tidx]) * (2*DATA_W)'(kern_q[kidx]);
    assign prod_c   = (|prod[2*DATA_W-1:DATA_W]) ? MAXV : prod[DATA_W-1:0];
    assign acc_sum  = acc_q + ACC_W'(prod_c);
    assign acc_sat  = (acc_sum > ACC_W'(MAXV)) ? MAXV : acc_sum[DATA_W-1:0];
    assign tap_last = (kr_q == K_LAST) && (kc_q == K_LAST);
    assign mac_last = tap_last && (or_q == M_LAST) && (oc_q == M_LAST);

    logic [SUM_W-1:0] sum;
    always_comb begin
        sum = '0;
        for (int i = 0; i < MM; i++) sum = sum + SUM_W'(res_q[i]);
    end

    logic [DATA_W-1:0]   diff, var_c;
    logic [2*DATA_W-1:0] sq, vshift;
    logic [VAR_W-1:0]    vsum;
    assign diff   = (res_q[vidx_q] > mean_q) ? res_q[vidx_q] - mean_q : mean_q - res_q[vidx_q];
    assign sq     = (2*DATA_W)'(diff) * (2*DATA_W)'(diff);
    assign vsum   = vacc_q + VAR_W'(sq);
    assign vshift = vacc_q[VAR_W-1:LOG_MM];
    assign var_c  = (|vshift[2*DATA_W-1:DATA_W]) ? MAXV : vshift[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_MAC;
            S_MAC:   if (mac_last) state_d = S_MEAN;
            S_MEAN:  state_d = S_VAR;
            S_VAR:   if (vidx_q == RIW'(MM - 1)) state_d = S_VFIN;
            S_VFIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NN; i++) tile_q[i] <= '0;
            for (int j = 0; j < KK; j++) kern_q[j] <= '0;
            for (int k = 0; k < MM; k++) res_q[k] <= '0;
            {mean_q, var_q, acc_q, vacc_q} <= '0;
            {or_q, oc_q, kr_q, kc_q, vidx_q} <= '0;
            {ctr_q, done_q, irq_q, mode_q} <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= 1'b0;
            if (!idle) ctr_q <= ctr_q + 16'd1;
            case (state_q)
                S_IDLE: begin
                    if (tile_wr) tile_q[NIW'(woff)] <= data_in[DATA_W-1:0];
                    if (kern_wr) kern_q[KIW'(woff)] <= data_in[DATA_W-1:0];
`ifdef AI_CONV_BOX_FILTER_EN
                    else if (box_sel) for (int j = 0; j < KK; j++) kern_q[j] <= DATA_W'(1);
`endif
                    if (mode_wr) mode_q <= data_in[1:0];
                    if (go) begin
                        for (int k = 0; k < MM; k++) res_q[k] <= '0;
                        {mean_q, var_q, acc_q, vacc_q} <= '0;
                        {or_q, oc_q, kr_q, kc_q, vidx_q} <= '0;
                        ctr_q  <= '0;
                        done_q <= 1'b0;
                    end
                end
                S_MAC: begin
                    if (kc_q != K_LAST) begin
                        kc_q  <= kc_q + CW'(1);
                        acc_q <= acc_sum;
                    end else begin
                        kc_q <= '0;
                        if (kr_q != K_LAST) begin
                            kr_q  <= kr_q + CW'(1);
                            acc_q <= acc_sum;
                        end else begin
                            kr_q        <= '0;
                            acc_q       <= '0;
                            res_q[ridx] <= acc_sat;
                            if (oc_q != M_LAST) begin
                                oc_q <= oc_q + CW'(1);
                            end else begin
                                oc_q <= '0;
                                or_q <= (or_q == M_LAST) ? '0 : or_q + CW'(1);
                            end
                        end
                    end
                end
                S_MEAN: mean_q <= sum[SUM_W-1:LOG_MM];
                S_VAR: begin
                    vacc_q <= vsum;
                    vidx_q <= vidx_q + RIW'(1);
                end
                S_VFIN: begin
                    var_q  <= var_c;
                    done_q <= 1'b1;
                    irq_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RESULT reads are shaped by MODE; normalisation is done here, not stored.
    logic [DATA_W-1:0] rraw, rval;
    always_comb begin
        rraw = res_q[RIW'(woff)];
        case (mode_q)
            2'd0:    rval = rraw;
            2'd1:    rval = (rraw > mean_q) ? rraw - mean_q : '0;
            2'd2:    rval = (woff == 6'd0) ? mean_q : '0;
            default: rval = (woff == 6'd0) ? var_q : '0;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (widx == 10'd0)      data_out = {done_q, 29'b0, !idle, go};
        else if (widx == 10'd1) data_out = {16'b0, ctr_q};
        else if (widx == 10'd2) data_out = {30'b0, mode_q};
        else if (is_tile)       data_out = 32'(tile_q[NIW'(woff)]);
        else if (is_kern)       data_out = 32'(kern_q[KIW'(woff)]);
        else if (is_res)        data_out = 32'(rval);
    end

    assign ctr  = ctr_q;
    assign busy = !idle;
    assign irq  = irq_q;
endmodule

// File: tb/tb_ai_conv_engine.sv
// Directed + randomized bench for ai_conv_engine against an arithmetic convolution/statistics model.
module tb_ai_conv_engine;
    localparam int N = 4, K = 3, M = 2, NN = 16, KK = 9, MM = 4;
    localparam int W_CTRL = 0, W_CYC = 1, W_MODE = 2, W_TILE = 64, W_KERN = 128, W_RES = 192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, data_in = '0;
    logic        wr_en = 1'b0, accel_select = 1'b0;
    logic [31:0] data_out;
    logic [15:0] ctr;
    logic        busy, irq;
`ifdef AI_CONV_BOX_FILTER_EN
    logic        box_sel = 1'b0;
`endif

    ai_conv_engine dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .accel_select(accel_select),
        .data_in(data_in),
`ifdef AI_CONV_BOX_FILTER_EN
        .box_sel(box_sel),
`endif
        .data_out(data_out), .ctr(ctr), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int t_m[NN], k_m[KK], r_m[MM], mean_m, var_m;
    int bcyc, irqs;
    bit tmo;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic bus_wr(input int w, input logic [31:0] d);
        @(negedge clk);
        addr = w * 4; data_in = d; wr_en = 1'b1; accel_select = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; accel_select = 1'b0;
    endtask

    task automatic bus_rd(input int w, output logic [31:0] d);
        @(negedge clk);
        addr = w * 4;
        #1 d = data_out;
    endtask

    task automatic load_dut();
        for (int i = 0; i < NN; i++) bus_wr(W_TILE + i, t_m[i]);
        for (int j = 0; j < KK; j++) bus_wr(W_KERN + j, k_m[j]);
    endtask

    // Valid convolution with clamped products/sums, then floor mean and saturated variance.
    task automatic compute_model();
        int s, p, tot, v, d;
        tot = 0;
        for (int oy = 0; oy < M; oy++)
            for (int ox = 0; ox < M; ox++) begin
                s = 0;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        p = t_m[(oy + ky) * N + ox + kx] * k_m[ky * K + kx];
                        s += (p > 255) ? 255 : p;
                    end
                r_m[oy * M + ox] = (s > 255) ? 255 : s;
                tot += r_m[oy * M + ox];
            end
        mean_m = tot / MM;
        v = 0;
        for (int k = 0; k < MM; k++) begin
            d = r_m[k] - mean_m;
            v += d * d;
        end
        var_m = (v / MM > 255) ? 255 : v / MM;
    endtask

    // Issue go and watch until the engine has been idle for three cycles.
    task automatic run_wait(output int bc, output int iq, output bit to);
        int idle_n;
        bc = 0; iq = 0; idle_n = 0; to = 1'b1;
        bus_wr(W_CTRL, 32'h1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (irq) iq++;
            if (busy) bc++;
            else begin
                idle_n++;
                if (idle_n == 3) begin to = 1'b0; break; end
            end
        end
    endtask

    task automatic check_results(input string tag);
        int e;
        for (int md = 0; md < 4; md++) begin
            bus_wr(W_MODE, md);
            for (int k = 0; k < MM; k++) begin
                case (md)
                    0: e = r_m[k];
                    1: e = (r_m[k] > mean_m) ? r_m[k] - mean_m : 0;
                    2: e = (k == 0) ? mean_m : 0;
                    default: e = (k == 0) ? var_m : 0;
                endcase
                bus_rd(W_RES + k, rd);
                check($sformatf("%s_m%0d_r%0d", tag, md, k), rd, e);
            end
        end
        bus_wr(W_MODE, 0);
    endtask

    task automatic full_run(input string tag);
        compute_model();
        load_dut();
        run_wait(bcyc, irqs, tmo);
        check({tag, "_timeout"}, 32'(tmo), 0);
        check({tag, "_busy_cycles"}, bcyc, 42);
        check({tag, "_irq_count"}, irqs, 1);
        check({tag, "_ctr"}, 32'(ctr), 42);
        bus_rd(W_CTRL, rd);
        check({tag, "_ctrl"}, rd, 32'h8000_0000);
        check_results(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_ctr", 32'(ctr), 0);
        bus_rd(W_CTRL, rd);  check("rst_ctrl", rd, 0);
        bus_rd(W_MODE, rd);  check("rst_mode", rd, 0);
        bus_rd(W_TILE + 7, rd); check("rst_tile7", rd, 0);
        bus_rd(W_RES, rd);   check("rst_res0", rd, 0);

        // All ones.
        for (int i = 0; i < NN; i++) t_m[i] = 1;
        for (int j = 0; j < KK; j++) k_m[j] = 1;
        full_run("ones");

        // Ramp tile, checked also against hand-computed values.
        for (int i = 0; i < NN; i++) t_m[i] = i;
        full_run("ramp");
        bus_rd(W_RES + 0, rd); check("ramp_raw0", rd, 45);
        bus_rd(W_RES + 1, rd); check("ramp_raw1", rd, 54);
        bus_rd(W_RES + 2, rd); check("ramp_raw2", rd, 81);
        bus_rd(W_RES + 3, rd); check("ramp_raw3", rd, 90);
        bus_wr(W_MODE, 1);
        bus_rd(W_RES + 3, rd); check("ramp_norm3", rd, 23);
        bus_wr(W_MODE, 2);
        bus_rd(W_RES, rd);     check("ramp_mean", rd, 67);
        bus_wr(W_MODE, 3);
        bus_rd(W_RES, rd);     check("ramp_var_sat", rd, 255);
        bus_rd(W_MODE, rd);    check("mode_readback", rd, 3);
        bus_wr(W_MODE, 0);

        // Saturation of products and sums.
        for (int i = 0; i < NN; i++) t_m[i] = 32'h20;
        for (int j = 0; j < KK; j++) k_m[j] = 32'h10;
        full_run("sat");

        bus_rd(3, rd);            check("unmapped_w3", rd, 0);
        bus_rd(W_TILE + NN, rd);  check("unmapped_tile", rd, 0);
        bus_rd(W_RES + MM, rd);   check("unmapped_res", rd, 0);
        bus_rd(256, rd);          check("unmapped_256", rd, 0);

        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NN; i++) t_m[i] = (it % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            for (int j = 0; j < KK; j++) k_m[j] = (it % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            full_run($sformatf("rnd%0d", it));
            bus_rd(W_TILE + 5, rd); check($sformatf("rnd%0d_tile5", it), rd, t_m[5]);
            bus_rd(W_KERN + 8, rd); check($sformatf("rnd%0d_kern8", it), rd, k_m[8]);
        end

        // Writes during a run must be ignored.
        for (int i = 0; i < NN; i++) t_m[i] = $urandom_range(0, 20);
        for (int j = 0; j < KK; j++) k_m[j] = $urandom_range(0, 9);
        compute_model();
        load_dut();
        bus_wr(W_CTRL, 1);
        repeat (9) @(negedge clk);
        bus_wr(W_KERN, 200);
        bus_wr(W_CTRL, 1);
        bus_wr(W_MODE, 2);
        irqs = 0; tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (irq) irqs++;
            if (!busy) begin tmo = 1'b0; break; end
        end
        check("busy_wr_timeout", 32'(tmo), 0);
        repeat (3) @(negedge clk);
        check("busy_wr_ctr", 32'(ctr), 42);
        bus_rd(W_KERN, rd);  check("busy_wr_kern0", rd, k_m[0]);
        bus_rd(W_MODE, rd);  check("busy_wr_mode", rd, 0);
        check_results("busy_wr");

        // Reset in the middle of a run.
        bus_wr(W_MODE, 1);
        bus_wr(W_CTRL, 1);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        bus_rd(W_CTRL, rd);     check("midrst_ctrl", rd, 0);
        bus_rd(W_CYC, rd);      check("midrst_cycles", rd, 0);
        bus_rd(W_MODE, rd);     check("midrst_mode", rd, 0);
        bus_rd(W_TILE + 3, rd); check("midrst_tile3", rd, 0);
        bus_rd(W_KERN + 4, rd); check("midrst_kern4", rd, 0);
        bus_rd(W_RES + 2, rd);  check("midrst_res2", rd, 0);
        irqs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq) irqs++;
        end
        check("midrst_no_irq", irqs, 0);
        for (int i = 0; i < NN; i++) t_m[i] = $urandom_range(0, 255);
        for (int j = 0; j < KK; j++) k_m[j] = $urandom_range(0, 3);
        full_run("after_rst");

`ifdef AI_CONV_BOX_FILTER_EN
        for (int i = 0; i < NN; i++) t_m[i] = i;
        for (int j = 0; j < KK; j++) k_m[j] = 2;
        load_dut();
        @(negedge clk) box_sel = 1'b1;
        @(negedge clk) box_sel = 1'b0;
        bus_rd(W_KERN + 6, rd); check("box_kern6", rd, 1);
        for (int j = 0; j < KK; j++) k_m[j] = 1;
        compute_model();
        run_wait(bcyc, irqs, tmo);
        check("box_timeout", 32'(tmo), 0);
        check_results("box");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
